uart_pattern_gen: RTL and testbench
===================================

// Module: uart_pattern_gen
// PURPOSE
//  Parametrised, synthesisable UART traffic generator and checker, driving the FPGA UART over the CPU register bus.
//  Sends a repeated fixed message, incrementing-counter or PRBS-8 pattern.
//  In loopback mode, reads back each received character and counts mismatches.
//  Sits beside the CPU bus master mux for board bring-up and soak tests.
// PARAMETERS
//  TOP_CLK_FREQ_HZ  50_000_000      input clock frequency (Hz), informational
//  MSG_LEN          12              characters in fixed message, 1..256
//  MSG              "Hello World!"  packed MSG_LEN*8 bits; char 0 in MSB byte
//  DATA_BITS        8               UART character width, 5..8
//  GAP_CYCLES       3               idle cycles after tx_start before first status poll, >=1
//  POLL_TIMEOUT     1_000_000       max cycles spent polling for one character
//  LOOPBACK_CHK     0               1 = read RX after each TX and compare
// PORTS
//  clk_i          in   1   clock
//  rst_ni         in   1   asynchronous active-low reset
//  start_i        in   1   1-cycle pulse: begin run; ignored while busy_o=1
//  stop_i         in   1   pulse: end run at next character boundary
//  mode_i         in   2   0 fixed MSG, 1 counter, 2 PRBS-8, 3 reserved (behaves as 0); sampled on start
//  repeat_i       in   16  characters to send; 0 = unlimited; sampled on start
//  busy_o         out  1   run in progress
//  done_o         out  1   1-cycle pulse when repeat_i characters sent
//  timeout_o      out  1   sticky; set on poll timeout, cleared on start
//  err_cnt_o      out  16  loopback mismatches, saturating; cleared on start
//  char_cnt_o     out  16  characters sent this run, wraps; cleared on start
//  wr_en_cpu_o    out  1   bus write enable
//  rd_en_cpu_o    out  1   bus read enable
//  cpu_addr_o     out  2   0 STAT, 1 CTRL, 2 TX, 3 RX
//  cpu_wr_data_o  out  32  bus write data
//  cpu_rd_data_i  in   32  bus read data, valid the cycle after rd_en_cpu_o
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, LFSR = 8'h01, message index 0. Asynchronous assertion; deasserts synchronously.
//  Bus outputs are combinational from state; all are 0 when a state does not drive them. One access per cycle.
//  FSM:
//   IDLE -start-> CFG_RD
//   CFG_RD (rd CTRL) -> CFG_WR
//   CFG_WR: write rd_data with bit0=1, [6:5]=[22:21]=DATA_BITS-5, bit16=1 -> TX_WR
//   TX_WR: write char to TX; [31:DATA_BITS]=0 -> ST_RD
//   ST_RD (rd CTRL) -> ST_WR
//   ST_WR: write rd_data with bit1=1 (tx_start) -> GAP
//   GAP: GAP_CYCLES cycles -> POLL_RD
//   POLL_RD (rd STAT) -> POLL_CHK
//   POLL_CHK: STAT[1]=1 -> POLL_RD; else LOOPBACK_CHK ? RXP_RD : NEXT
//   RXP_RD (rd STAT) -> RXP_CHK
//   RXP_CHK: STAT[0]=1 -> RX_RD; else RXP_RD
//   RX_RD (rd RX) -> RX_CHK
//   RX_CHK: compare rd_data[DATA_BITS-1:0] with sent char -> NEXT
//   NEXT: char_cnt_o++, advance pattern.
//    If (repeat_i!=0 and count==repeat_i): pulse done_o, -> IDLE.
//    Else if stop pending: -> IDLE, no done_o. Else -> TX_WR.
//   TOUT -> IDLE, timeout_o=1
//  Poll timer cleared on GAP exit; counts all POLL_*/RXP_* cycles. Reaching POLL_TIMEOUT -> TOUT.
//  busy_o = 1 in every state except IDLE.
//  stop_i is latched while busy; cleared on entry to IDLE.
//  Patterns:
//   fixed: MSG[idx], idx wraps MSG_LEN-1 -> 0, masked to DATA_BITS.
//   counter: 0,1,2.. mod 2^DATA_BITS.
//   PRBS: Fibonacci LFSR x^8+x^6+x^5+x^4+1, seed 8'h01, output masked to DATA_BITS.
//   Pattern state resets to start value on every start.
//  Mismatch in RX_CHK: err_cnt_o += 1, saturating at 16'hFFFF.
//  Simultaneous start_i and stop_i in IDLE: start wins; stop ignored.
//  Reset mid-run: bus enables drop immediately; UART is left in its current state.
// TESTING
//  Fixed mode, repeat_i=12, bus model with 10-cycle busy -> TX writes carry "Hello World!"; done_o pulses once; char_cnt_o=12.
//  Counter mode, DATA_BITS=5, repeat_i=40 -> TX data 0..31,0..7; CFG_WR writes [6:5]=[22:21]=2'b00.
//  PRBS, LOOPBACK_CHK=1, RX echoes TX -> first chars 8'h01,8'h02,...; err_cnt_o=0. Corrupt char 3 -> err_cnt_o=1.
//  STAT[1] held 1, POLL_TIMEOUT=100 -> timeout_o=1 after 100 poll cycles; busy_o=0; next start clears timeout_o.
//  repeat_i=0, stop_i pulsed mid-poll -> current char completes; IDLE follows NEXT; no done_o.
//  rst_ni pulled low mid-TX_WR -> all outputs 0 in same cycle; fresh start replays from char 0.

Source files
------------

// File: rtl/uart_pattern_gen.sv
// Purpose: UART traffic generator/checker that drives a register-mapped UART (fixed msg, counter, PRBS-8).
// Latency: one bus access per cycle; per character ~8 + GAP_CYCLES cycles plus UART busy/RX wait time.
// Backpressure: polls STAT[1] (TX busy) and STAT[0] (RX valid); a character stuck > POLL_TIMEOUT cycles aborts the run.
module uart_pattern_gen #(
  parameter int                   TOP_CLK_FREQ_HZ = 50_000_000,
  parameter int                   MSG_LEN         = 12,
  parameter logic [MSG_LEN*8-1:0] MSG             = "Hello World!",
  parameter int                   DATA_BITS       = 8,
  parameter int                   GAP_CYCLES      = 3,
  parameter int                   POLL_TIMEOUT    = 1_000_000,
  parameter int                   LOOPBACK_CHK    = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [1:0]  mode_i,
  input  logic [15:0] repeat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] char_cnt_o,
  output logic        wr_en_cpu_o,
  output logic        rd_en_cpu_o,
  output logic [1:0]  cpu_addr_o,
  output logic [31:0] cpu_wr_data_o,
  input  logic [31:0] cpu_rd_data_i
);

  localparam int         TW    = $clog2(POLL_TIMEOUT + 1);
  localparam int         GW    = $clog2(GAP_CYCLES + 1);
  localparam logic [1:0] DB    = 2'(DATA_BITS - 5);
  localparam logic [7:0] DMASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [1:0] A_STAT = 2'd0, A_CTRL = 2'd1, A_TX = 2'd2, A_RX = 2'd3;

  // Out-of-range parameters are rejected at elaboration rather than producing silent garbage.
  if (DATA_BITS < 5 || DATA_BITS > 8 || MSG_LEN < 1 || MSG_LEN > 256 ||
      GAP_CYCLES < 1 || POLL_TIMEOUT < 1 || TOP_CLK_FREQ_HZ < 1) begin : g_bad_param
    $error("uart_pattern_gen: parameter out of range");
  end

  typedef enum logic [3:0] {
    IDLE, CFG_RD, CFG_WR, TX_WR, ST_RD, ST_WR, GAP, POLL_RD,
    POLL_CHK, RXP_RD, RXP_CHK, RX_RD, RX_CHK, NEXT, TOUT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [15:0]      repeat_q;
  logic [7:0]       idx_q, cnt_q, lfsr_q;
  logic [GW-1:0]    gap_q;
  logic [TW-1:0]    timer_q;
  logic             stop_q, done_q, timeout_q;
  logic [15:0]      err_q, chars_q;
  logic [MSG_LEN*8-1:0] msg_sh;
  logic [7:0]       pat_raw, cur_char;
  logic             in_poll, tmo, last;

  // Current character of the selected pattern; mode 3 falls back to the fixed message.
  always_comb begin
    msg_sh = MSG << {idx_q, 3'b000};
    case (mode_q)
      2'd1:    pat_raw = cnt_q;
      2'd2:    pat_raw = lfsr_q;
      default: pat_raw = msg_sh[MSG_LEN*8-1 -: 8];
    endcase
    cur_char = pat_raw & DMASK;
  end

  assign in_poll = (state_q == POLL_RD) || (state_q == POLL_CHK) ||
                   (state_q == RXP_RD)  || (state_q == RXP_CHK);
  assign tmo     = in_poll && (timer_q == TW'(POLL_TIMEOUT - 1));
  assign last    = (repeat_q != 16'd0) && ((chars_q + 16'd1) == repeat_q);

  // Next-state and bus drive; the bus is purely a function of state so reset drops it immediately.
  always_comb begin
    state_d       = state_q;
    wr_en_cpu_o   = 1'b0;
    rd_en_cpu_o   = 1'b0;
    cpu_addr_o    = 2'd0;
    cpu_wr_data_o = 32'd0;
    case (state_q)
      IDLE:     if (start_i) state_d = CFG_RD;
      CFG_RD:   begin rd_en_cpu_o = 1'b1; cpu_addr_o = A_CTRL; state_d = CFG_WR; end
      CFG_WR: begin
        wr_en_cpu_o          = 1'b1;
        cpu_addr_o           = A_CTRL;
        cpu_wr_data_o        = cpu_rd_data_i;
        cpu_wr_data_o[0]     = 1'b1;
        cpu_wr_data_o[6:5]   = DB;
        cpu_wr_data_o[16]    = 1'b1;
        cpu_wr_data_o[22:21] = DB;
        state_d              = TX_WR;
      end
      TX_WR: begin
        wr_en_cpu_o   = 1'b1;
        cpu_addr_o    = A_TX;
        cpu_wr_data_o = {24'd0, cur_char};
        state_d       = ST_RD;
      end
      ST_RD:    begin rd_en_cpu_o = 1'b1; cpu_addr_o = A_CTRL; state_d = ST_WR; end
      ST_WR: begin
        wr_en_cpu_o   = 1'b1;
        cpu_addr_o    = A_CTRL;
        cpu_wr_data_o = cpu_rd_data_i | 32'h2;
        state_d       = GAP;
      end
      GAP:      if (gap_q == GW'(GAP_CYCLES - 1)) state_d = POLL_RD;
      POLL_RD:  begin rd_en_cpu_o = 1'b1; cpu_addr_o = A_STAT; state_d = POLL_CHK; end
      POLL_CHK: begin
        if (cpu_rd_data_i[1])       state_d = POLL_RD;
        else if (LOOPBACK_CHK != 0) state_d = RXP_RD;
        else                        state_d = NEXT;
      end
      RXP_RD:   begin rd_en_cpu_o = 1'b1; cpu_addr_o = A_STAT; state_d = RXP_CHK; end
      RXP_CHK:  state_d = cpu_rd_data_i[0] ? RX_RD : RXP_RD;
      RX_RD:    begin rd_en_cpu_o = 1'b1; cpu_addr_o = A_RX; state_d = RX_CHK; end
      RX_CHK:   state_d = NEXT;
      NEXT:     state_d = (last || stop_q) ? IDLE : TX_WR;
      TOUT:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (tmo) state_d = TOUT;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Run configuration, pattern generators, timers and status counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= 2'd0;
      repeat_q  <= 16'd0;
      idx_q     <= 8'd0;
      cnt_q     <= 8'd0;
      lfsr_q    <= 8'h01;
      gap_q     <= '0;
      timer_q   <= '0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 16'd0;
      chars_q   <= 16'd0;
    end else begin
      done_q  <= 1'b0;
      gap_q   <= (state_q == GAP) ? gap_q + GW'(1) : '0;
      timer_q <= in_poll ? timer_q + TW'(1) : '0;
      if (state_q == IDLE && start_i) begin
        mode_q    <= mode_i;
        repeat_q  <= repeat_i;
        idx_q     <= 8'd0;
        cnt_q     <= 8'd0;
        lfsr_q    <= 8'h01;
        timeout_q <= 1'b0;
        err_q     <= 16'd0;
        chars_q   <= 16'd0;
      end
      if (state_q == RX_CHK && cpu_rd_data_i[DATA_BITS-1:0] != cur_char[DATA_BITS-1:0] &&
          err_q != 16'hFFFF)
        err_q <= err_q + 16'd1;
      if (state_q == NEXT) begin
        chars_q <= chars_q + 16'd1;
        idx_q   <= (idx_q == 8'(MSG_LEN - 1)) ? 8'd0 : idx_q + 8'd1;
        cnt_q   <= cnt_q + 8'd1;
        lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        done_q  <= last;
      end
      if (state_q == TOUT) timeout_q <= 1'b1;
      // Stop is only remembered during a run, and forgotten whenever the run ends.
      if (state_d == IDLE)                  stop_q <= 1'b0;
      else if (state_q != IDLE && stop_i)   stop_q <= 1'b1;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign timeout_o  = timeout_q;
  assign err_cnt_o  = err_q;
  assign char_cnt_o = chars_q;

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Purpose: randomized scoreboard bench for uart_pattern_gen with a register-level UART model.
// Latency: expected TX characters queued at start; monitor pops on every TX register write.
// Backpressure: UART model holds STAT[1] busy for a fixed time per character (or forever on demand).
module tb_uart_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start [2];
  logic        stop  [2];
  logic [1:0]  mode  [2];
  logic [15:0] rpt   [2];
  logic        busy  [2];
  logic        done  [2];
  logic        tout  [2];
  logic [15:0] errc  [2];
  logic [15:0] chc   [2];
  logic        wr    [2];
  logic        rd    [2];
  logic [1:0]  addr  [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdat  [2];

  // Instance 0: 8-bit chars, loopback, short timeout. Instance 1: 5-bit chars, no loopback, GAP=1.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_pattern_gen #(
      .DATA_BITS   (g == 0 ? 8 : 5),
      .GAP_CYCLES  (g == 0 ? 3 : 1),
      .POLL_TIMEOUT(g == 0 ? 100 : 1000),
      .LOOPBACK_CHK(g == 0 ? 1 : 0)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start[g]),
      .stop_i       (stop[g]),
      .mode_i       (mode[g]),
      .repeat_i     (rpt[g]),
      .busy_o       (busy[g]),
      .done_o       (done[g]),
      .timeout_o    (tout[g]),
      .err_cnt_o    (errc[g]),
      .char_cnt_o   (chc[g]),
      .wr_en_cpu_o  (wr[g]),
      .rd_en_cpu_o  (rd[g]),
      .cpu_addr_o   (addr[g]),
      .cpu_wr_data_o(wdat[g]),
      .cpu_rd_data_i(rdat[g])
    );
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ctrl [2];
  int          busy_cnt [2];
  bit          force_busy = 1'b0;
  bit          rx_avail [2];
  bit          pend [2];
  logic [7:0]  rx_data [2];
  logic [7:0]  last_tx [2];
  int          tx_cnt [2];
  int          stat_reads [2];
  int          done_cnt [2];
  bit          first_ctrl [2];
  int          corrupt_idx = -1;
  logic [7:0]  exp_q0 [$];
  logic [7:0]  exp_q1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pattern: straight from the pattern definitions, one character per index.
  task automatic push_exp(input int i, input int m, input int n);
    string      msg  = "Hello World!";
    int         db   = (i == 0) ? 8 : 5;
    logic [7:0] mask = 8'((1 << db) - 1);
    logic [7:0] lfsr = 8'h01;
    logic [7:0] v;
    for (int k = 0; k < n; k++) begin
      case (m)
        1:       v = 8'(k % (1 << db));
        2: begin v = lfsr & mask; lfsr = {lfsr[6:0], ^(lfsr & 8'hB8)}; end
        default: v = msg[k % 12] & mask;
      endcase
      if (i == 0) exp_q0.push_back(v);
      else        exp_q1.push_back(v);
    end
  endtask

  // UART register model plus scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [7:0]  e;
    logic [31:0] cmask, cexp;
    int          db5;
    for (int i = 0; i < 2; i++) begin
      chk("one_access", {31'd0, wr[i] & rd[i]}, 32'd0);
      if (!wr[i]) chk("wdat_idle", wdat[i], 32'd0);
      if (!wr[i] && !rd[i]) chk("addr_idle", {30'd0, addr[i]}, 32'd0);
      if (done[i]) done_cnt[i]++;
      if (busy_cnt[i] > 0) begin
        busy_cnt[i]--;
        if (busy_cnt[i] == 0 && pend[i]) begin
          rx_avail[i] = 1'b1; rx_data[i] = last_tx[i]; pend[i] = 1'b0;
        end
      end
      if (rd[i]) begin
        case (addr[i])
          2'd0: begin
            rdat[i] = {30'd0, (busy_cnt[i] != 0) || force_busy, rx_avail[i]};
            stat_reads[i]++;
          end
          2'd1: rdat[i] = ctrl[i];
          2'd3: begin rdat[i] = {24'd0, rx_data[i]}; rx_avail[i] = 1'b0; end
          default: rdat[i] = 32'd0;
        endcase
      end
      if (wr[i] && addr[i] == 2'd1) begin
        if (first_ctrl[i]) begin
          db5   = (i == 0) ? 3 : 0;
          cmask = 32'h0061_0061;
          cexp  = (ctrl[i] & ~cmask) | 32'h0001_0001 | (32'(db5) << 5) | (32'(db5) << 21);
          chk("cfg_wr", wdat[i], cexp);
          first_ctrl[i] = 1'b0;
        end else begin
          chk("st_wr", wdat[i], ctrl[i] | 32'h2);
        end
        if (wdat[i][1]) busy_cnt[i] = (i == 0) ? 10 : 2;
        ctrl[i] = wdat[i] & ~32'h2;
      end
      if (wr[i] && addr[i] == 2'd2) begin
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk("tx_data", wdat[i], {24'd0, e});
        end
        last_tx[i] = wdat[i][7:0] ^ ((i == 0 && tx_cnt[i] == corrupt_idx) ? 8'h01 : 8'h00);
        pend[i] = 1'b1;
        tx_cnt[i]++;
        stat_reads[i] = 0;
      end
    end
  end

  task automatic outs_zero(input int i, input string name);
    chk(name, {26'd0, busy[i], done[i], tout[i], wr[i], rd[i], addr[i] != 2'd0}, 32'd0);
    chk(name, {errc[i], chc[i]}, 32'd0);
    chk(name, wdat[i], 32'd0);
  endtask

  task automatic flush();
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic start_run(input int i, input int m, input int n, input int cor, input bit with_stop);
    push_exp(i, m, (n == 0) ? 300 : n);
    ctrl[i] = $urandom & ~32'h2;
    first_ctrl[i] = 1'b1; busy_cnt[i] = 0; rx_avail[i] = 1'b0; pend[i] = 1'b0;
    tx_cnt[i] = 0; done_cnt[i] = 0; stat_reads[i] = 0; corrupt_idx = cor;
    @(negedge clk);
    start[i] = 1'b1; stop[i] = with_stop; mode[i] = 2'(m); rpt[i] = 16'(n);
    @(negedge clk);
    start[i] = 1'b0; stop[i] = 1'b0; mode[i] = 2'($urandom); rpt[i] = 16'($urandom);
    chk("busy_on", {31'd0, busy[i]}, 32'd1);
    chk("tout_clr", {31'd0, tout[i]}, 32'd0);
    chk("cnt_clr", {errc[i], chc[i]}, 32'd0);
  endtask

  task automatic wait_idle(input int i);
    int k = 0;
    while (busy[i] && k < 20000) begin @(negedge clk); k++; end
    chk("run_end", {31'd0, busy[i]}, 32'd0);
    @(negedge clk);
  endtask

  task automatic finish_run(input int i, input int n, input int exp_err);
    wait_idle(i);
    chk("char_cnt", {16'd0, chc[i]}, 32'(n));
    chk("tx_cnt", tx_cnt[i], 32'(n));
    chk("done_cnt", done_cnt[i], 32'd1);
    chk("done_pulse", {31'd0, done[i]}, 32'd0);
    chk("sb_empty", (i == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
    chk("err_cnt", {16'd0, errc[i]}, 32'(exp_err));
    chk("tout_idle", {31'd0, tout[i]}, 32'd0);
    flush();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, m, n, cor, ee, i;
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      start[j] = 1'b0; stop[j] = 1'b0; mode[j] = 2'd0; rpt[j] = 16'd0;
      rdat[j] = 32'd0; ctrl[j] = 32'd0; busy_cnt[j] = 0; rx_avail[j] = 1'b0; pend[j] = 1'b0;
      rx_data[j] = 8'd0; last_tx[j] = 8'd0; tx_cnt[j] = 0; stat_reads[j] = 0;
      done_cnt[j] = 0; first_ctrl[j] = 1'b0;
    end
    #3;
    outs_zero(0, "reset0");
    outs_zero(1, "reset1");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fixed message, 12 chars, echo loopback clean.
    start_run(0, 0, 12, -1, 1'b0);
    finish_run(0, 12, 0);

    // Counter on 5-bit instance wraps at 32.
    start_run(1, 1, 40, -1, 1'b0);
    finish_run(1, 40, 0);

    // PRBS clean, then with character 3 corrupted on the echo path.
    start_run(0, 2, 10, -1, 1'b0);
    finish_run(0, 10, 0);
    start_run(0, 2, 10, 3, 1'b0);
    finish_run(0, 10, 1);

    // TX busy forever: timeout after 100 poll cycles (50 STAT reads).
    force_busy = 1'b1;
    start_run(0, 0, 5, -1, 1'b0);
    wait_idle(0);
    chk("tout_set", {31'd0, tout[0]}, 32'd1);
    chk("tout_stat_reads", stat_reads[0], 32'd50);
    chk("tout_tx", tx_cnt[0], 32'd1);
    chk("tout_chars", {16'd0, chc[0]}, 32'd0);
    chk("tout_done", done_cnt[0], 32'd0);
    force_busy = 1'b0;
    flush();

    // Next start clears timeout; mode 3 behaves as fixed.
    start_run(0, 3, 3, -1, 1'b0);
    finish_run(0, 3, 0);

    // Unlimited run, stop mid-poll of the third character.
    start_run(0, 1, 0, -1, 1'b0);
    k = 0;
    while (!(tx_cnt[0] == 3 && stat_reads[0] > 0) && k < 5000) begin @(negedge clk); k++; end
    chk("stop_reach", tx_cnt[0], 32'd3);
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    wait_idle(0);
    chk("stop_chars", {16'd0, chc[0]}, 32'd3);
    chk("stop_tx", tx_cnt[0], 32'd3);
    chk("stop_nodone", done_cnt[0], 32'd0);
    chk("stop_err", {16'd0, errc[0]}, 32'd0);
    flush();

    // Start and stop together in IDLE: the run completes normally.
    start_run(0, 0, 4, -1, 1'b1);
    finish_run(0, 4, 0);

    // Asynchronous reset during a TX write, then a fresh run restarts at char 0.
    start_run(0, 0, 0, -1, 1'b0);
    k = 0;
    while (!(chc[0] == 16'd2 && wr[0] && addr[0] == 2'd2) && k < 5000) begin @(negedge clk); k++; end
    chk("rst_reach", {16'd0, chc[0]}, 32'd2);
    #2 rst_n = 1'b0;
    #1 outs_zero(0, "rst_mid");
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    start_run(0, 0, 3, -1, 1'b0);
    finish_run(0, 3, 0);

    // Randomized runs on both instances.
    for (int r = 0; r < 8; r++) begin
      i   = r % 2;
      m   = int'($urandom % 4);
      n   = int'($urandom_range(1, 20));
      cor = (i == 0) ? int'($urandom_range(0, n)) : -1;
      ee  = (i == 0 && cor < n) ? 1 : 0;
      start_run(i, m, n, cor, 1'b0);
      finish_run(i, n, ee);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
